// File: rtl/mem_arbiter_rr2_pkg.sv
// Shared bus definitions for the PicoRV32-native memory bus blocks:
// field widths, default error word and the arbiter state type.
package mem_arbiter_rr2_pkg;

   localparam int unsigned MEM_ADDR_W = 32;
   localparam int unsigned MEM_DATA_W = 32;
   localparam int unsigned MEM_STRB_W = 4;

   localparam logic [MEM_DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Response watchdog: counts cycles while enabled and flags the last
// permitted cycle. A TIMEOUT_CYCLES of 0 disables expiry.
module mem_arb_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

   logic [CNT_W-1:0] count;

   // Cycle counter: cleared outside BUSY, saturates on the expiry cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + CNT_W'(1);
      end
   end

   // Expiry flag for the final cycle of the allowed window
   always_comb begin
      expire = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);
   end

endmodule

// File: rtl/mem_arbiter_rr2.sv
// Two-master round-robin arbiter for one PicoRV32-native memory port,
// with a response watchdog that completes hung transactions with an
// error word and a bus_err pulse.
module mem_arbiter_rr2
   import mem_arbiter_rr2_pkg::*;
#(
   parameter int unsigned               TIMEOUT_CYCLES = 256,
   parameter logic [MEM_DATA_W-1:0]     ERR_RDATA      = DEFAULT_ERR_RDATA
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_valid,
   input  logic                  m0_instr,
   input  logic [MEM_ADDR_W-1:0] m0_addr,
   input  logic [MEM_DATA_W-1:0] m0_wdata,
   input  logic [MEM_STRB_W-1:0] m0_wstrb,
   output logic                  m0_ready,
   output logic [MEM_DATA_W-1:0] m0_rdata,
   input  logic                  m1_valid,
   input  logic                  m1_instr,
   input  logic [MEM_ADDR_W-1:0] m1_addr,
   input  logic [MEM_DATA_W-1:0] m1_wdata,
   input  logic [MEM_STRB_W-1:0] m1_wstrb,
   output logic                  m1_ready,
   output logic [MEM_DATA_W-1:0] m1_rdata,
   output logic                  s_valid,
   output logic                  s_instr,
   output logic [MEM_ADDR_W-1:0] s_addr,
   output logic [MEM_DATA_W-1:0] s_wdata,
   output logic [MEM_STRB_W-1:0] s_wstrb,
   input  logic                  s_ready,
   input  logic [MEM_DATA_W-1:0] s_rdata,
   output logic                  bus_err
);

   arb_state_t            state, state_next;
   logic                  grant, grant_next;
   logic                  last;
   logic                  done;
   logic                  expire;
   logic                  timer_clear;
   logic [MEM_DATA_W-1:0] rsp_data;

   mem_arb_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .enable (s_valid),
      .expire (expire)
   );

   // State, grant and last-served registers; last starts at 1 so m0 wins the first tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         grant <= 1'b0;
         last  <= 1'b1;
      end else begin
         state <= state_next;
         grant <= grant_next;
         if ((state == ST_BUSY) && done) begin
            last <= grant;
         end
      end
   end

   // Next-state and grant pick; completion by slave ready or watchdog expiry
   always_comb begin
      state_next = state;
      grant_next = grant;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (m0_valid || m1_valid) begin
               state_next = ST_BUSY;
               grant_next = (m0_valid && m1_valid) ? ~last : m1_valid;
            end
         end
         ST_BUSY: begin
            done = s_ready || expire;
            if (done) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Slave-side request muxed from the granted master; s_valid is the registered BUSY state
   always_comb begin
      timer_clear = (state == ST_IDLE);
      s_valid     = (state == ST_BUSY);
      s_instr     = grant ? m1_instr : m0_instr;
      s_addr      = grant ? m1_addr  : m0_addr;
      s_wdata     = grant ? m1_wdata : m0_wdata;
      s_wstrb     = grant ? m1_wstrb : m0_wstrb;
   end

   // Master-side response: ready pulse and data only toward the granted master
   always_comb begin
      rsp_data = s_ready ? s_rdata : ERR_RDATA;
      m0_ready = done && !grant;
      m1_ready = done && grant;
      m0_rdata = m0_ready ? rsp_data : '0;
      m1_rdata = m1_ready ? rsp_data : '0;
      bus_err  = done && !s_ready;
   end

endmodule
